// File: rtl/msbs_t3_batch_ctrl_pkg.sv
// Shared definitions for the mSBS key-equation batch sequencers (t=2/3/4).
// Holds the 3-bit binary state encoding and the slot-counter width helper.
package msbs_t3_batch_ctrl_pkg;

  // Sequencer states, 3-bit binary encoding shared by all sequencer variants.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_FILL  = 3'd2;
  localparam logic [2:0] ST_PAD   = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;
  localparam logic [2:0] ST_HOLD  = 3'd5;

  // Width of a counter that must represent 0..slots inclusive.
  function automatic int ctrl_cnt_w(input int slots);
    return $clog2(slots + 1);
  endfunction

endpackage

// File: rtl/msbs_t3_batch_ctrl.sv
// Batch sequencer for the t=3 mSBS key-equation stage.
// Accepts one (S1,S3,S5) triple per codeword, groups KEY_EQ_BUF codewords into a
// batch (zero-padding partial batches on flush), drives the stage's Srst/en/done
// controls with aligned syndromes, and holds the finished batch until downstream
// accepts it. Every output is a register.
module msbs_t3_batch_ctrl
  import msbs_t3_batch_ctrl_pkg::*;
#(
  parameter int  GF_LEN     = 10,
  parameter int  KEY_EQ_BUF = 8,
  localparam int CNT_W      = ctrl_cnt_w(KEY_EQ_BUF)
) (
  input  logic              clk,
  input  logic              in_ctr_Arst,
  input  logic              in_ctr_Srst,
  input  logic              in_synd_valid,
  output logic              out_synd_ready,
  input  logic [GF_LEN-1:0] in_synd1,
  input  logic [GF_LEN-1:0] in_synd3,
  input  logic [GF_LEN-1:0] in_synd5,
  output logic [GF_LEN-1:0] out_synd1,
  output logic [GF_LEN-1:0] out_synd3,
  output logic [GF_LEN-1:0] out_synd5,
  output logic              out_ctr_Srst,
  output logic              out_ctr_en,
  output logic              out_ctr_done,
  input  logic              in_flush,
  output logic              out_blk_valid,
  input  logic              in_blk_ready,
  output logic [CNT_W-1:0]  out_blk_cnt,
  output logic              out_busy
);

  // Slot count before the increment that fills the batch.
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(KEY_EQ_BUF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;          // slots issued to the stage (real + pad)
  logic [CNT_W-1:0]  blk_cnt_q, blk_cnt_d;  // real codewords only
  logic              flush_pend_q, flush_pend_d;
  logic              ready_q, srst_q, en_q, done_q, blk_valid_q, busy_q;
  logic [GF_LEN-1:0] synd1_q, synd3_q, synd5_q;

  logic accept;     // a triple is taken on this edge
  logic pad_slot;   // a zero slot is issued on this edge
  logic slot_take;  // any slot (real or pad) is issued on this edge
  logic slot_last;  // the issued slot is the final one of the batch

  // Next-state and slot decode; a synchronous abort overrides everything.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; an unassigned path in always_comb infers a latch.
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    accept       = 1'b0;
    pad_slot     = 1'b0;

    case (state_q)
      ST_IDLE:  state_d = ST_CLEAR;
      ST_CLEAR: state_d = ST_FILL;
      ST_FILL: begin
        accept = in_synd_valid & ready_q;
        if (accept) begin
          if (cnt_q == LAST_SLOT) begin
            // A full batch completes normally even if a flush arrives with it.
            state_d      = ST_DRAIN;
            flush_pend_d = 1'b0;
          end else if (in_flush) begin
            flush_pend_d = 1'b1;
          end
        end else if (flush_pend_q || (in_flush && (cnt_q != '0))) begin
          pad_slot     = 1'b1;
          flush_pend_d = 1'b0;
          state_d      = (cnt_q == LAST_SLOT) ? ST_HOLD : ST_PAD;
        end
      end
      ST_PAD: begin
        pad_slot = 1'b1;
        if (cnt_q == LAST_SLOT) state_d = ST_HOLD;
      end
      ST_DRAIN: state_d = ST_HOLD;
      ST_HOLD:  if (blk_valid_q && in_blk_ready) state_d = ST_CLEAR;
      default:  state_d = ST_IDLE;
    endcase

    if (in_ctr_Srst) begin
      state_d      = ST_CLEAR;
      flush_pend_d = 1'b0;
      accept       = 1'b0;
      pad_slot     = 1'b0;
    end
  end

  assign slot_take = accept | pad_slot;
  assign slot_last = slot_take && (cnt_q == LAST_SLOT);

  // Counter next values: any entry into CLEAR restarts the batch.
  always_comb begin
    cnt_d     = cnt_q;
    blk_cnt_d = blk_cnt_q;
    if (state_d == ST_CLEAR) begin
      cnt_d     = '0;
      blk_cnt_d = '0;
    end else begin
      if (slot_take) cnt_d     = cnt_q + CNT_ONE;
      if (accept)    blk_cnt_d = blk_cnt_q + CNT_ONE;
    end
  end

  // FSM state and registered control outputs, decoded from the next state.
  always_ff @(posedge clk or posedge in_ctr_Arst) begin
    if (in_ctr_Arst) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b0;
      srst_q      <= 1'b0;
      en_q        <= 1'b0;
      done_q      <= 1'b0;
      blk_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q     <= state_d;
      ready_q     <= (state_d == ST_FILL) && !flush_pend_d;
      srst_q      <= (state_d == ST_CLEAR);
      en_q        <= slot_take;
      done_q      <= slot_last;
      // Valid rises one cycle after HOLD is entered, so it never shares a
      // cycle with done and the stage outputs have settled.
      blk_valid_q <= (state_q == ST_HOLD) && (state_d == ST_HOLD);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  // Slot counter, real-codeword counter and pending-flush flag.
  always_ff @(posedge clk or posedge in_ctr_Arst) begin
    if (in_ctr_Arst) begin
      cnt_q        <= '0;
      blk_cnt_q    <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      blk_cnt_q    <= blk_cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Syndrome registers: load on accept, zero on pad slots, otherwise hold.
  // They are reset because every output must read 0 during reset.
  always_ff @(posedge clk or posedge in_ctr_Arst) begin
    if (in_ctr_Arst) begin
      synd1_q <= '0;
      synd3_q <= '0;
      synd5_q <= '0;
    end else if (accept) begin
      synd1_q <= in_synd1;
      synd3_q <= in_synd3;
      synd5_q <= in_synd5;
    end else if (pad_slot) begin
      synd1_q <= '0;
      synd3_q <= '0;
      synd5_q <= '0;
    end
  end

  assign out_synd_ready = ready_q;
  assign out_synd1      = synd1_q;
  assign out_synd3      = synd3_q;
  assign out_synd5      = synd5_q;
  assign out_ctr_Srst   = srst_q;
  assign out_ctr_en     = en_q;
  assign out_ctr_done   = done_q;
  assign out_blk_valid  = blk_valid_q;
  assign out_blk_cnt    = blk_cnt_q;
  assign out_busy       = busy_q;

endmodule
